mem_wb_reg: RTL and testbench

MEM_WB_REG -- requirements
Module: mem_wb_reg

---
 rtl/mem_wb_pkg.sv | 15 +
 rtl/pipe_reg.sv | 15 +
 rtl/mem_wb_reg.sv | 58 +++++
 tb/tb_mem_wb_reg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared widths, write-back control bit positions and payload type for the MEM/WB stage register.
package mem_wb_pkg;
    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;
    localparam int WB_W        = 2;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef struct packed {
        logic [WB_W-1:0]   control;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  write_reg;
    } mem_wb_payload_t;
endpackage

// File: rtl/pipe_reg.sv
// Parameterised-width register with synchronous active-low clear and load enable.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!clr_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on a cache hit, inserts a bubble (control cleared, data held) on a miss.
// Optional MEM_WB_FLUSH_EN adds a flush input that bubbles the stage regardless of data_hit.
module mem_wb_reg #(
    parameter int DATA_W = mem_wb_pkg::DATA_W,
    parameter int REG_W  = mem_wb_pkg::REG_W,
    parameter int WB_W   = mem_wb_pkg::WB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_hit,
`ifdef MEM_WB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [WB_W-1:0]   control_wb_in,
    input  logic [DATA_W-1:0] Read_data_in,
    input  logic [DATA_W-1:0] ALU_rslt_in,
    input  logic [REG_W-1:0]  Write_reg_in,
    output logic [WB_W-1:0]   mem_control_wb,
    output logic [DATA_W-1:0] Read_data,
    output logic [DATA_W-1:0] mem_ALU_result,
    output logic [REG_W-1:0]  mem_Write_reg
);
    import mem_wb_pkg::*;

    localparam int PAY_W = 2*DATA_W + REG_W;

    logic             kill;
    logic [PAY_W-1:0] pay_d;
    logic [PAY_W-1:0] pay_q;

`ifdef MEM_WB_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // Control is cleared on reset, miss or flush; data only loads on a clean hit so
    // stale data (and any X on the inputs during a miss) never reaches the outputs.
    pipe_reg #(.W(WB_W)) u_ctrl (
        .clk   (clk),
        .clr_n (rst_n & data_hit & ~kill),
        .en    (1'b1),
        .d     (control_wb_in),
        .q     (mem_control_wb)
    );

    assign pay_d = {Read_data_in, ALU_rslt_in, Write_reg_in};

    pipe_reg #(.W(PAY_W)) u_data (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (data_hit & ~kill),
        .d     (pay_d),
        .q     (pay_q)
    );

    assign {Read_data, mem_ALU_result, mem_Write_reg} = pay_q;
endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: directed vector table, hand sequences, and random stimulus vs a reference model.
module tb_mem_wb_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_hit = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  c_in = '0;
    logic [31:0] rd_in = '0, alu_in = '0;
    logic [4:0]  wr_in = '0;
    logic [1:0]  c_out;
    logic [31:0] rd_out, alu_out;
    logic [4:0]  wr_out;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [1:0]  m_c = '0;
    logic [31:0] m_rd = '0, m_alu = '0;
    logic [4:0]  m_wr = '0;

    always #5 clk = ~clk;

    mem_wb_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_hit       (data_hit),
`ifdef MEM_WB_FLUSH_EN
        .flush          (flush),
`endif
        .control_wb_in  (c_in),
        .Read_data_in   (rd_in),
        .ALU_rslt_in    (alu_in),
        .Write_reg_in   (wr_in),
        .mem_control_wb (c_out),
        .Read_data      (rd_out),
        .mem_ALU_result (alu_out),
        .mem_Write_reg  (wr_out)
    );

    typedef struct {
        logic        rst_n, hit;
        logic [1:0]  c;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic [1:0]  ec;
        logic [31:0] erd, ealu;
        logic [4:0]  ewr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ec, input logic [31:0] erd,
                           input logic [31:0] ealu, input logic [4:0] ewr);
        chk({tag, ".ctrl"}, {30'd0, c_out}, {30'd0, ec});
        chk({tag, ".rd"},   rd_out, erd);
        chk({tag, ".alu"},  alu_out, ealu);
        chk({tag, ".wr"},   {27'd0, wr_out}, {27'd0, ewr});
    endtask

    // Behavioural rule for one edge: reset clears, flush/miss bubble the control only, hit loads.
    task automatic model_edge();
        if (!rst_n) begin
            m_c = '0; m_rd = '0; m_alu = '0; m_wr = '0;
        end else if (flush || !data_hit) begin
            m_c = '0;
        end else begin
            m_c = c_in; m_rd = rd_in; m_alu = alu_in; m_wr = wr_in;
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic [1:0] c,
                         input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
        @(negedge clk);
        rst_n = r; data_hit = h; c_in = c; rd_in = rd; alu_in = alu; wr_in = wr;
    endtask

    task automatic edge_and_settle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'd1, 32'd2, 32'd3, 5'd4, 2'd0, 32'd0, 32'd0, 5'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'd2, 32'd3, 5'd4, 2'd0, 32'd0, 32'd0, 5'd0};
        vecs[2]  = '{1'b1, 1'b1, 2'd1, 32'd2, 32'd3, 5'd4, 2'd1, 32'd2, 32'd3, 5'd4};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'hDEADBEEF, 32'h55, 5'd31, 2'd0, 32'd2, 32'd3, 5'd4};
        vecs[4]  = '{1'b1, 1'b0, 2'd3, 32'hDEADBEEF, 32'h55, 5'd31, 2'd0, 32'd2, 32'd3, 5'd4};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 32'hDEADBEEF, 32'h55, 5'd31, 2'd0, 32'd2, 32'd3, 5'd4};
        vecs[6]  = '{1'b1, 1'b1, 2'd3, 32'hDEADBEEF, 32'h55, 5'd31, 2'd3, 32'hDEADBEEF, 32'h55, 5'd31};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 5'd0, 2'd0, 32'd0, 32'd0, 5'd0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 32'h1234_5678, 5'd17, 2'd2, 32'hA5A5_0001, 32'h1234_5678, 5'd17};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'd7, 32'd9, 5'd5, 2'd0, 32'd0, 32'd0, 5'd0};
        vecs[11] = '{1'b1, 1'b1, 2'd2, 32'd7, 32'd9, 5'd5, 2'd2, 32'd7, 32'd9, 5'd5};

        // Directed table: outputs must not move before the edge, then match exactly one edge later.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst_n, vecs[i].hit, vecs[i].c, vecs[i].rd, vecs[i].alu, vecs[i].wr);
            #1;
            if (i > 0)
                chk_all($sformatf("v%0d.pre", i), vecs[i-1].ec, vecs[i-1].erd, vecs[i-1].ealu, vecs[i-1].ewr);
            edge_and_settle();
            chk_all($sformatf("v%0d", i), vecs[i].ec, vecs[i].erd, vecs[i].ealu, vecs[i].ewr);
        end

        // X on data inputs during a miss must stay out of the outputs.
        drive(1'b1, 1'b0, 2'bxx, 'x, 'x, 'x);
        edge_and_settle();
        chk_all("xmiss", 2'd0, 32'd7, 32'd9, 5'd5);
        drive(1'b1, 1'b1, 2'd1, 32'h0BAD_F00D, 32'h8000_0000, 5'd1);
        edge_and_settle();
        chk_all("xmiss.recover", 2'd1, 32'h0BAD_F00D, 32'h8000_0000, 5'd1);

`ifdef MEM_WB_FLUSH_EN
        drive(1'b1, 1'b1, 2'd2, 32'h1111, 32'h2222, 5'd9);
        flush = 1'b1;
        edge_and_settle();
        chk_all("flush", 2'd0, 32'h0BAD_F00D, 32'h8000_0000, 5'd1);
        @(negedge clk);
        flush = 1'b0;
        edge_and_settle();
        chk_all("flush.release", 2'd2, 32'h1111, 32'h2222, 5'd9);
`endif

        // Random stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic r, h;
            r = ($urandom_range(0, 15) != 0);
            h = ($urandom_range(0, 2) != 0);
            if (!h && $urandom_range(0, 1) == 1)
                drive(r, h, 2'bxx, 'x, 'x, 'x);
            else
                drive(r, h, 2'($urandom), $urandom, $urandom, 5'($urandom));
`ifdef MEM_WB_FLUSH_EN
            flush = ($urandom_range(0, 7) == 0);
`endif
            edge_and_settle();
            chk_all($sformatf("rnd%0d", i), m_c, m_rd, m_alu, m_wr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
